// File: rtl/ifid_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of (pc, inst) pairs with flush.
// Optional same-cycle bypass into an empty queue when IFID_QUEUE_BYPASS_EN is defined.
module ifid_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [CW-1:0]            in_pc,
    input  logic [CW-1:0]            in_inst,
    output logic                     in_ready,
    input  logic                     jump_stall,
    input  logic                     full_stall,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [CW-1:0]            out_pc,
    output logic [CW-1:0]            out_inst,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [CW-1:0] pc_mem   [DEPTH];
    logic [CW-1:0] inst_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt_q;
    logic          stall, has_data, byp, push, pop;

    assign stall    = jump_stall | full_stall;
    assign has_data = (cnt_q != '0);
    assign in_ready = (cnt_q != FULL_CNT);
    assign count    = cnt_q;

`ifdef IFID_QUEUE_BYPASS_EN
    // An instruction arriving at an idle, unstalled queue goes straight to decode.
    assign byp = !has_data && in_valid && !stall && !flush;
`else
    assign byp = 1'b0;
`endif

    assign push = in_valid && in_ready && !flush && !byp;
    assign pop  = has_data && !stall && !flush;

    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_inst  = '0;
        if (has_data) begin
            out_valid = 1'b1;
            out_pc    = pc_mem[rd_ptr];
            out_inst  = inst_mem[rd_ptr];
        end else if (byp) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_inst  = in_inst;
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push && rst) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            cnt_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule
